// File: rtl/spi_bootload_sequencer.sv
// Host-side sequencer that turns one flash/ICAP operation into the register-bus
// write/read sequence expected by spi_bootload, including checksum and status polling.
module spi_bootload_sequencer #(
  parameter int unsigned PAGE_BYTES = 256,
  parameter int unsigned TIMEOUT_W  = 28
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [7:0]  wdat_i,
  input  logic        wdat_valid_i,
  output logic        wdat_ready_o,
  output logic [7:0]  rdat_o,
  output logic        rdat_valid_o,
  input  logic        rdat_ready_i,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] status_o,
  output logic [31:0] id_o,
  output logic [1:0]  bl_adr_o,
  output logic [15:0] bl_dat_o,
  output logic        bl_en_o,
  output logic        bl_wr_o,
  input  logic [15:0] bl_dat_i,
  input  logic        bl_valid_i
);
  localparam int unsigned CntW = $clog2(PAGE_BYTES + 1);
  localparam logic [7:0] OpProg = 8'h02;
  localparam logic [7:0] OpRead = 8'h03;
  localparam logic [7:0] OpId   = 8'h9E;

  typedef enum logic [3:0] {
    StIdle, StFrst, StFill, StAdrl, StAdrh, StCmd, StStat, StDrain, StIdl, StIdh, StDone
  } state_e;

  state_e               r_state, w_state_d;
  logic [7:0]           r_op, w_op_d;
  logic [31:0]          r_addr, w_addr_d;
  logic                 r_gap, w_gap_d;
  logic                 r_err, w_err_d;
  logic                 r_wpend, w_wpend_d;
  logic [7:0]           r_wbyte, w_wbyte_d;
  logic                 r_rhold, w_rhold_d;
  logic [7:0]           r_rbyte, w_rbyte_d;
  logic [CntW-1:0]      r_bcnt, w_bcnt_d;
  logic [TIMEOUT_W-1:0] r_tcnt, w_tcnt_d;
  logic [15:0]          r_status, w_status_d;
  logic [31:0]          r_id, w_id_d;

  logic [7:0] w_csum;
  logic       w_tmo, w_last, w_rd_req, w_rd_done;
  logic [1:0] w_rd_adr;

  assign w_csum = r_op ^ r_addr[7:0] ^ r_addr[15:8] ^ r_addr[23:16] ^ r_addr[31:24];
  assign w_tmo  = &r_tcnt;
  assign w_last = (r_bcnt == CntW'(PAGE_BYTES - 1));

  // A read is requested after the mandatory idle bus cycle, and in DRAIN only
  // once the previous byte has been handed off.
  always_comb begin
    w_rd_req = 1'b0;
    w_rd_adr = 2'd0;
    unique case (r_state)
      StStat:  begin w_rd_req = !r_gap;            w_rd_adr = 2'd3; end
      StDrain: begin w_rd_req = !r_gap && !r_rhold; w_rd_adr = 2'd0; end
      StIdl:   begin w_rd_req = !r_gap;            w_rd_adr = 2'd1; end
      StIdh:   begin w_rd_req = !r_gap;            w_rd_adr = 2'd2; end
      default: ;
    endcase
  end
  assign w_rd_done = w_rd_req && !w_tmo && bl_valid_i;

  always_comb begin
    w_state_d  = r_state;
    w_op_d     = r_op;
    w_addr_d   = r_addr;
    w_gap_d    = 1'b0;
    w_err_d    = r_err;
    w_wpend_d  = r_wpend;
    w_wbyte_d  = r_wbyte;
    w_rhold_d  = r_rhold;
    w_rbyte_d  = r_rbyte;
    w_bcnt_d   = r_bcnt;
    w_tcnt_d   = '0;
    w_status_d = r_status;
    w_id_d     = r_id;
    req_ready_o  = 1'b0;
    wdat_ready_o = 1'b0;
    rdat_valid_o = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    bl_adr_o     = 2'd0;
    bl_dat_o     = 16'h0000;
    bl_en_o      = 1'b0;
    bl_wr_o      = 1'b0;

    unique case (r_state)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_op_d    = req_op_i;
          w_addr_d  = req_addr_i;
          w_err_d   = 1'b0;
          w_bcnt_d  = '0;
          w_wpend_d = 1'b0;
          w_rhold_d = 1'b0;
          w_state_d = (req_op_i == OpProg || req_op_i == OpRead) ? StFrst : StAdrl;
        end
      end
      StFrst: begin
        bl_en_o = 1'b1; bl_wr_o = 1'b1; bl_adr_o = 2'd0; bl_dat_o = 16'h8000;
        w_gap_d   = 1'b1;
        w_state_d = (r_op == OpProg) ? StFill : StAdrl;
      end
      StFill: begin
        // The accept cycle itself keeps the bus idle, so no extra gap is inserted.
        if (r_wpend) begin
          bl_en_o = 1'b1; bl_wr_o = 1'b1; bl_adr_o = 2'd0; bl_dat_o = {8'h00, r_wbyte};
          w_wpend_d = 1'b0;
          w_gap_d   = 1'b1;
          if (w_last) begin
            w_bcnt_d  = '0;
            w_state_d = StAdrl;
          end else begin
            w_bcnt_d = r_bcnt + 1'b1;
          end
        end else begin
          wdat_ready_o = 1'b1;
          if (wdat_valid_i) begin
            w_wbyte_d = wdat_i;
            w_wpend_d = 1'b1;
          end
        end
      end
      StAdrl: if (!r_gap) begin
        bl_en_o = 1'b1; bl_wr_o = 1'b1; bl_adr_o = 2'd1; bl_dat_o = r_addr[15:0];
        w_gap_d = 1'b1; w_state_d = StAdrh;
      end
      StAdrh: if (!r_gap) begin
        bl_en_o = 1'b1; bl_wr_o = 1'b1; bl_adr_o = 2'd2; bl_dat_o = r_addr[31:16];
        w_gap_d = 1'b1; w_state_d = StCmd;
      end
      StCmd: if (!r_gap) begin
        bl_en_o = 1'b1; bl_wr_o = 1'b1; bl_adr_o = 2'd3; bl_dat_o = {w_csum, r_op};
        w_gap_d = 1'b1; w_state_d = StStat;
      end
      StStat: if (w_rd_done) begin
        w_status_d = bl_dat_i;
        w_state_d  = (r_op == OpRead) ? StDrain : (r_op == OpId) ? StIdl : StDone;
      end
      StDrain: begin
        if (r_rhold) begin
          rdat_valid_o = 1'b1;
          if (rdat_ready_i) begin
            w_rhold_d = 1'b0;
            if (w_last) w_state_d = StDone;
            else        w_bcnt_d  = r_bcnt + 1'b1;
          end
        end else if (w_rd_done) begin
          w_rbyte_d = bl_dat_i[7:0];
          w_rhold_d = 1'b1;
          if (!bl_dat_i[8]) w_err_d = 1'b1;
        end
      end
      StIdl: if (w_rd_done) begin
        w_id_d[15:0] = bl_dat_i;
        w_state_d    = StIdh;
      end
      StIdh: if (w_rd_done) begin
        w_id_d[31:16] = bl_dat_i;
        w_state_d     = StDone;
      end
      StDone: begin
        done_o    = 1'b1;
        err_o     = r_err;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // Shared read handshake and wait-counter/timeout handling.
    if (w_rd_req) begin
      bl_adr_o = w_rd_adr;
      if (w_tmo) begin
        w_err_d   = 1'b1;
        w_rhold_d = 1'b0;
        w_state_d = StDone;
        if (r_state == StStat) w_status_d = 16'hFFFF;
      end else begin
        bl_en_o = 1'b1;
        if (bl_valid_i) w_gap_d  = 1'b1;
        else            w_tcnt_d = r_tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_op     <= 8'h00;
      r_addr   <= 32'h0;
      r_gap    <= 1'b0;
      r_err    <= 1'b0;
      r_wpend  <= 1'b0;
      r_wbyte  <= 8'h00;
      r_rhold  <= 1'b0;
      r_rbyte  <= 8'h00;
      r_bcnt   <= '0;
      r_tcnt   <= '0;
      r_status <= 16'h0;
      r_id     <= 32'h0;
    end else begin
      r_state  <= w_state_d;
      r_op     <= w_op_d;
      r_addr   <= w_addr_d;
      r_gap    <= w_gap_d;
      r_err    <= w_err_d;
      r_wpend  <= w_wpend_d;
      r_wbyte  <= w_wbyte_d;
      r_rhold  <= w_rhold_d;
      r_rbyte  <= w_rbyte_d;
      r_bcnt   <= w_bcnt_d;
      r_tcnt   <= w_tcnt_d;
      r_status <= w_status_d;
      r_id     <= w_id_d;
    end
  end

  assign rdat_o   = r_rbyte;
  assign status_o = r_status;
  assign id_o     = r_id;
endmodule

// File: tb/tb_spi_bootload_sequencer.sv
// Scoreboard bench for spi_bootload_sequencer: a register-bus stub answers reads,
// expected bus writes and read-back bytes are queued and checked as they appear.
module tb_spi_bootload_sequencer;
  localparam int unsigned PageBytes = 256;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic [7:0]  req_op_i = 8'h00;
  logic [31:0] req_addr_i = 32'h0;
  logic [7:0]  wdat_i = 8'h00;
  logic        wdat_valid_i = 1'b0, wdat_ready_o;
  logic [7:0]  rdat_o;
  logic        rdat_valid_o, rdat_ready_i = 1'b1;
  logic        done_o, err_o;
  logic [15:0] status_o;
  logic [31:0] id_o;
  logic [1:0]  bl_adr_o;
  logic [15:0] bl_dat_o;
  logic        bl_en_o, bl_wr_o;
  logic [15:0] bl_dat_i = 16'h0;
  logic        bl_valid_i = 1'b0;

  always #5 clk = ~clk;

  spi_bootload_sequencer #(.PAGE_BYTES(PageBytes), .TIMEOUT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i),
    .wdat_i(wdat_i), .wdat_valid_i(wdat_valid_i), .wdat_ready_o(wdat_ready_o),
    .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .rdat_ready_i(rdat_ready_i),
    .done_o(done_o), .err_o(err_o), .status_o(status_o), .id_o(id_o),
    .bl_adr_o(bl_adr_o), .bl_dat_o(bl_dat_o), .bl_en_o(bl_en_o), .bl_wr_o(bl_wr_o),
    .bl_dat_i(bl_dat_i), .bl_valid_i(bl_valid_i)
  );

  int n_chk = 0, n_pass = 0;
  logic [17:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [15:0] rd_words[$];
  logic [15:0] stat_word = 16'h0, id_lo = 16'h0, id_hi = 16'h0;
  bit          stub_mute = 1'b0, rd_bp = 1'b0;
  int          stub_wait = 0;

  // Bus stub and read-side backpressure, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    rdat_ready_i = rd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    if (bl_en_o && !bl_wr_o && !stub_mute) begin
      if (stub_wait > 0) stub_wait--;
      else if (!bl_valid_i) begin
        bl_valid_i = 1'b1;
        case (bl_adr_o)
          2'd0: begin
            if (rd_words.size() != 0) bl_dat_i = rd_words.pop_front();
            else bl_dat_i = 16'h0100;
          end
          2'd1: bl_dat_i = id_lo;
          2'd2: bl_dat_i = id_hi;
          default: bl_dat_i = stat_word;
        endcase
      end
    end else begin
      bl_valid_i = 1'b0;
      stub_wait  = $urandom_range(0, 3);
    end
  end

  // Scoreboard: every bus write and every read-byte handshake is matched in order.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (bl_en_o && bl_wr_o) begin
        n_chk++;
        if (exp_wr.size() == 0)
          $display("FAIL bus_write unexpected: got adr=%0d dat=%h", bl_adr_o, bl_dat_o);
        else begin
          logic [17:0] e;
          e = exp_wr.pop_front();
          if ({bl_adr_o, bl_dat_o} !== e)
            $display("FAIL bus_write: got adr=%0d dat=%h, want adr=%0d dat=%h",
                     bl_adr_o, bl_dat_o, e[17:16], e[15:0]);
          else n_pass++;
        end
      end
      if (rdat_valid_o && rdat_ready_i) begin
        n_chk++;
        if (exp_rd.size() == 0) $display("FAIL rdat unexpected: got %h", rdat_o);
        else begin
          logic [7:0] b;
          b = exp_rd.pop_front();
          if (rdat_o !== b) $display("FAIL rdat: got %h want %h", rdat_o, b);
          else n_pass++;
        end
      end
    end
  end

  task automatic start_req(input logic [7:0] op, input logic [31:0] addr);
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready_o) break;
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit seen, output logic e);
    seen = 1'b0; e = 1'bx;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (done_o) begin seen = 1'b1; e = err_o; break; end
    end
  endtask

  task automatic feed(input int n, input logic [7:0] xv, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      int k;
      wdat_valid_i = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wdat_valid_i = 1'b1;
      wdat_i = 8'(i) ^ xv;
      k = 0;
      do begin @(negedge clk); k++; end while (!wdat_ready_o && k < 50);
      if (!wdat_ready_o) stalls++;
      @(posedge clk); #1;
    end
    wdat_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({req_ready_o, wdat_ready_o, rdat_valid_o, rdat_o, done_o, err_o, status_o, id_o,
         bl_adr_o, bl_dat_o, bl_en_o, bl_wr_o} !== {1'b1, 80'd0})
      $display("FAIL reset_values: req_ready=%b bl_en=%b done=%b status=%h id=%h",
               req_ready_o, bl_en_o, done_o, status_o, id_o);
    else n_pass++;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_erase();
    logic [6:0] pat;
    bit seen;
    logic e;
    stat_word = 16'h5A3C;
    exp_wr.push_back({2'd1, 16'h0000});
    exp_wr.push_back({2'd2, 16'h0000});
    exp_wr.push_back({2'd3, 16'hD8D8});
    start_req(8'hD8, 32'h0);
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pat = {pat[5:0], bl_en_o};
    end
    n_chk++;
    if (pat !== 7'b1010101) $display("FAIL erase_bus_timing: got %b want 1010101", pat);
    else n_pass++;
    wait_done(100, seen, e);
    n_chk++;
    if ({seen, e} !== 2'b10) $display("FAIL erase_done: got seen=%b err=%b want 1/0", seen, e);
    else n_pass++;
    n_chk++;
    if (status_o !== 16'h5A3C) $display("FAIL erase_status: got %h want 5a3c", status_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({done_o, req_ready_o} !== 2'b01)
      $display("FAIL done_one_cycle: got done=%b ready=%b want 0/1", done_o, req_ready_o);
    else n_pass++;
    n_chk++;
    if (exp_wr.size() != 0) $display("FAIL erase_writes_left: got %0d want 0", exp_wr.size());
    else n_pass++;
  endtask

  task automatic test_program(input logic [31:0] addr, input logic [7:0] xv,
                              input logic [7:0] csum);
    int stalls;
    bit seen;
    logic e;
    stat_word = 16'h0081;
    exp_wr.push_back({2'd0, 16'h8000});
    for (int i = 0; i < PageBytes; i++) exp_wr.push_back({2'd0, 8'h00, 8'(i) ^ xv});
    exp_wr.push_back({2'd1, addr[15:0]});
    exp_wr.push_back({2'd2, addr[31:16]});
    exp_wr.push_back({2'd3, csum, 8'h02});
    start_req(8'h02, addr);
    feed(PageBytes, xv, stalls);
    n_chk++;
    if (stalls != 0) $display("FAIL program_wdat_stalls: got %0d want 0", stalls);
    else n_pass++;
    wait_done(200, seen, e);
    n_chk++;
    if ({seen, e} !== 2'b10) $display("FAIL program_done: got seen=%b err=%b want 1/0", seen, e);
    else n_pass++;
    n_chk++;
    if (status_o !== 16'h0081 || exp_wr.size() != 0)
      $display("FAIL program_end: got status=%h left=%0d want 0081/0", status_o, exp_wr.size());
    else n_pass++;
  endtask

  task automatic test_read(input int bad_idx);
    bit seen;
    logic e;
    rd_bp = 1'b1;
    stat_word = 16'h00C3;
    exp_wr.push_back({2'd0, 16'h8000});
    exp_wr.push_back({2'd1, 16'h0000});
    exp_wr.push_back({2'd2, 16'h0001});
    exp_wr.push_back({2'd3, 16'h0203});
    for (int i = 0; i < PageBytes; i++) begin
      logic [15:0] w;
      w = (i == bad_idx) ? 16'h0042 : {8'h01, 8'($urandom)};
      rd_words.push_back(w);
      exp_rd.push_back(w[7:0]);
    end
    start_req(8'h03, 32'h0001_0000);
    wait_done(8000, seen, e);
    rd_bp = 1'b0;
    n_chk++;
    if ({seen, e} !== {1'b1, bad_idx >= 0})
      $display("FAIL read_done: got seen=%b err=%b want 1/%0b", seen, e, bad_idx >= 0);
    else n_pass++;
    n_chk++;
    if (status_o !== 16'h00C3 || exp_rd.size() != 0 || exp_wr.size() != 0)
      $display("FAIL read_end: got status=%h bytes_left=%0d writes_left=%0d want 00c3/0/0",
               status_o, exp_rd.size(), exp_wr.size());
    else n_pass++;
  endtask

  task automatic test_id();
    bit seen;
    logic e;
    id_lo = 16'h20BA; id_hi = 16'h1019; stat_word = 16'h0001;
    exp_wr.push_back({2'd1, 16'h0000});
    exp_wr.push_back({2'd2, 16'h0000});
    exp_wr.push_back({2'd3, 16'h9E9E});
    start_req(8'h9E, 32'h0);
    wait_done(100, seen, e);
    n_chk++;
    if ({seen, e} !== 2'b10 || id_o !== 32'h1019_20BA)
      $display("FAIL idcode: got seen=%b err=%b id=%h want 1/0/101920ba", seen, e, id_o);
    else n_pass++;
  endtask

  task automatic test_icap();
    bit seen;
    logic e;
    id_lo = 16'hDEAD; id_hi = 16'hBEEF; stat_word = 16'h0007;
    exp_wr.push_back({2'd1, 16'h6533});
    exp_wr.push_back({2'd2, 16'h4279});
    exp_wr.push_back({2'd3, 16'h93FE});
    start_req(8'hFE, 32'h4279_6533);
    wait_done(100, seen, e);
    n_chk++;
    if ({seen, e} !== 2'b10 || status_o !== 16'h0007)
      $display("FAIL icap_done: got seen=%b err=%b status=%h want 1/0/0007", seen, e, status_o);
    else n_pass++;
    n_chk++;
    if (id_o !== 32'h1019_20BA) $display("FAIL id_held: got %h want 101920ba", id_o);
    else n_pass++;
    n_chk++;
    if (exp_wr.size() != 0) $display("FAIL icap_writes_left: got %0d want 0", exp_wr.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int en_cycles;
    bit seen;
    logic e;
    stub_mute = 1'b1;
    exp_wr.push_back({2'd1, 16'h00FF});
    exp_wr.push_back({2'd2, 16'h0000});
    exp_wr.push_back({2'd3, 16'h27D8});
    start_req(8'hD8, 32'h0000_00FF);
    en_cycles = 0; seen = 1'b0; e = 1'bx;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bl_en_o && !bl_wr_o) en_cycles++;
      if (done_o) begin seen = 1'b1; e = err_o; break; end
    end
    stub_mute = 1'b0;
    n_chk++;
    if (en_cycles != 255) $display("FAIL timeout_wait: got %0d want 255", en_cycles);
    else n_pass++;
    n_chk++;
    if ({seen, e} !== 2'b11 || status_o !== 16'hFFFF)
      $display("FAIL timeout_done: got seen=%b err=%b status=%h want 1/1/ffff", seen, e, status_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    int stalls;
    bit seen;
    logic e;
    exp_wr.push_back({2'd0, 16'h8000});
    for (int i = 0; i < 10; i++) exp_wr.push_back({2'd0, 8'h00, 8'(i)});
    start_req(8'h02, 32'h1234_5678);
    feed(10, 8'h00, stalls);
    repeat (3) @(posedge clk);
    n_chk++;
    if (exp_wr.size() != 0 || stalls != 0)
      $display("FAIL partial_fill: got left=%0d stalls=%0d want 0/0", exp_wr.size(), stalls);
    else n_pass++;
    @(posedge clk); #2;
    rst_i = 1'b1;
    #1;
    n_chk++;
    if ({bl_en_o, wdat_ready_o, req_ready_o, done_o} !== 4'b0010)
      $display("FAIL async_reset: got en=%b wready=%b rready=%b done=%b want 0/0/1/0",
               bl_en_o, wdat_ready_o, req_ready_o, done_o);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    wait_done(10, seen, e);
    n_chk++;
    if (seen) $display("FAIL reset_no_done: got done=1 want 0");
    else n_pass++;
    test_program(32'h1234_5678, 8'hFF, 8'h0A);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_erase();
    test_program(32'h0001_0000, 8'h00, 8'h03);
    test_read(-1);
    test_read(77);
    test_id();
    test_icap();
    test_timeout();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
